idct_8_stage_2_inner: RTL and testbench
=======================================

// Module: idct_8_stage_2_inner
// PURPOSE
//   Inverse of the 8-lane DCT stage-2 butterfly. Recovers x[0..7] from stage-2 outputs o[0..7].
//   Forward relation being inverted:
//     o0=x0+x3  o1=x1+x2  o2=x1-x2  o3=x0-x3
//     o4=x4+x5  o5=x5+x6  o6=x6+x7  o7=x7
//   Lanes 4..7 form a serial dependency chain, solved one lane per cycle to share a single
//   subtractor. Sits in the visc_DCT accelerator unit between the FIFO controller and the
//   inverse stage-1 block.
// PARAMETERS
//   LANE_W   64   width of one lane, two's complement
//   LANES    8    lane count; fixed, must be 8
//   DATA_W = LANES*LANE_W (localparam, 512)
// PORTS
//   clk         in   1       clock
//   rst         in   1       reset, synchronous, active-high
//   i_data_in   in   DATA_W  o[k] at bits [k*LANE_W +: LANE_W]
//   i_valid     in   1       input word valid
//   i_ready     out  1       block can accept a word
//   o_data_out  out  DATA_W  x[k] at bits [k*LANE_W +: LANE_W]
//   o_valid     out  1       result valid
//   o_ready     in   1       downstream accepts the result
// BEHAVIOUR
//   - Reset: state=IDLE, step=0, in/out registers=0, o_valid=0. i_ready=0 while rst is high.
//   - Transfer rules: input transfers on an edge with i_valid&&i_ready; output transfers on an
//     edge with o_valid&&o_ready. o_data_out is registered and stays stable while o_valid&&!o_ready.
//   - FSM:
//     IDLE: i_ready=1. On an input transfer, latch i_data_in into in_reg, step<=0, go to SOLVE.
//     SOLVE: i_ready=0, o_valid=0. Each step writes on one edge:
//       step0: x0,x1,x2,x3 (parallel half-butterflies) and x7=o7
//       step1: x6=o6-x7
//       step2: x5=o5-x6
//       step3: x4=o4-x5, then go to DONE
//     DONE: o_valid=1, i_ready=o_ready.
//       - transfer out with no input: go to IDLE
//       - transfer out with a simultaneous input: latch the new word, step<=0, go to SOLVE
//       - no output transfer: hold
//   - Latency: input edge E0 -> o_valid high after edge E4. Back-to-back throughput: 1 word per 5 cycles.
//   - Arithmetic: operands sign-extended to LANE_W+1 bits.
//       x0=(o0+o3)>>>1  x3=(o0-o3)>>>1  x1=(o1+o2)>>>1  x2=(o1-o2)>>>1
//     Results are the low LANE_W bits. Chain subtractions wrap modulo 2^LANE_W. Recovery is exact
//     when the forward stage did not overflow. An odd sum/difference (invalid forward data)
//     truncates toward -inf, with no flag raised.
//   - rst mid-SOLVE or mid-DONE: the word in flight is discarded, the IDLE reset state is reached
//     on the next edge, and no o_valid is emitted.
//   - i_valid while in SOLVE is ignored (i_ready=0); upstream must hold the word.
//   - o_ready toggling while not in DONE has no effect.
// STRUCTURE
//   - Package dct_pkg (shared with the forward stages):
//     - LANE_W and LANES constants
//     - lane index constants L0..L7
//     - state enum {IDLE, SOLVE, DONE}
//     - 2-bit step type
//   - Sub-module idct_half_butterfly #(LANE_W): (a,b) -> ((a+b)>>>1, (a-b)>>>1), combinational.
//     Instantiated twice (lane pairs 0/3 and 1/2).
//   - Chain subtractor, step counter and FSM stay in this module.
// TESTING
//   T1 basic: o=[5,5,-1,-3,11,13,15,8] (lane0..7) -> x=[1,2,3,4,5,6,7,8], o_valid 4 edges after
//      accept, o_ready=1.
//   T2 negatives: o=[-5,-5,1,3,-11,-13,-15,-8] -> x=[-1,-2,-3,-4,-5,-6,-7,-8].
//   T3 backpressure: hold o_ready=0 for 10 cycles after o_valid -> o_data_out stable, i_ready=0,
//      a new i_valid is not accepted; raise o_ready -> one output transfer.
//   T4 back-to-back: i_valid held with T1 then T2 words, o_ready=1 -> T2 accepted on T1's output
//      edge; T2 result 5 cycles after T1's.
//   T5 reset mid-SOLVE: assert rst at step2 -> next cycle o_valid=0, o_data_out=0, IDLE; i_ready=1
//      after rst drops; a fresh T1 word still gives the correct result.
//   T6 wrap: o4=0, o5=0, o6=0, o7=0x8000_0000_0000_0000 -> x7=0x8000..., x6=0x8000..., x5=0x8000...,
//      x4=0x8000... (mod 2^64).

Source files
------------

// File: rtl/dct_pkg.sv
// Shared definitions for the visc_DCT stage blocks.
package dct_pkg;

  localparam int LANE_W = 64;
  localparam int LANES  = 8;

  localparam int unsigned L0 = 0;
  localparam int unsigned L1 = 1;
  localparam int unsigned L2 = 2;
  localparam int unsigned L3 = 3;
  localparam int unsigned L4 = 4;
  localparam int unsigned L5 = 5;
  localparam int unsigned L6 = 6;
  localparam int unsigned L7 = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SOLVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef logic [1:0] step_t;

endpackage

// File: rtl/idct_half_butterfly.sv
// Inverse half-butterfly: (a,b) -> ((a+b)>>>1, (a-b)>>>1) at LANE_W+1 bits.
module idct_half_butterfly #(
  parameter int LANE_W = 64
) (
  input  logic [LANE_W-1:0] i_a,
  input  logic [LANE_W-1:0] i_b,
  output logic [LANE_W-1:0] o_sum_half,
  output logic [LANE_W-1:0] o_diff_half
);

  logic [LANE_W:0] w_a_ext;
  logic [LANE_W:0] w_b_ext;
  logic [LANE_W:0] w_sum;
  logic [LANE_W:0] w_diff;

  assign w_a_ext = {i_a[LANE_W-1], i_a};
  assign w_b_ext = {i_b[LANE_W-1], i_b};
  assign w_sum   = w_a_ext + w_b_ext;
  assign w_diff  = w_a_ext - w_b_ext;

  // Arithmetic shift by one then keeping the low LANE_W bits is just bits [LANE_W:1].
  assign o_sum_half  = w_sum[LANE_W:1];
  assign o_diff_half = w_diff[LANE_W:1];

endmodule

// File: rtl/idct_8_stage_2_inner.sv
// Inverse DCT stage-2 butterfly: recovers x[0..7] from stage-2 outputs o[0..7].
// Lanes 0..3 are solved in parallel; lanes 7..4 are solved serially through one subtractor.
module idct_8_stage_2_inner #(
  parameter  int LANE_W = dct_pkg::LANE_W,
  parameter  int LANES  = dct_pkg::LANES,
  localparam int DATA_W = LANES * LANE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] i_data_in,
  input  logic              i_valid,
  output logic              i_ready,
  output logic [DATA_W-1:0] o_data_out,
  output logic              o_valid,
  input  logic              o_ready
);

  import dct_pkg::*;

  state_t            r_state;
  step_t             r_step;
  logic [DATA_W-1:0] r_in;
  logic [DATA_W-1:0] r_out;
  logic              r_valid;

  logic              w_in_xfer;
  logic              w_out_xfer;
  logic [LANE_W-1:0] w_x0;
  logic [LANE_W-1:0] w_x1;
  logic [LANE_W-1:0] w_x2;
  logic [LANE_W-1:0] w_x3;
  logic [LANE_W-1:0] w_minuend;
  logic [LANE_W-1:0] w_subtrahend;
  logic [LANE_W-1:0] w_diff;

  assign i_ready    = !rst && ((r_state == IDLE) || ((r_state == DONE) && o_ready));
  assign w_in_xfer  = i_valid && i_ready;
  assign w_out_xfer = r_valid && o_ready;
  assign o_data_out = r_out;
  assign o_valid    = r_valid;

  idct_half_butterfly #(.LANE_W(LANE_W)) u_bfly_03 (
    .i_a         (r_in[L0*LANE_W +: LANE_W]),
    .i_b         (r_in[L3*LANE_W +: LANE_W]),
    .o_sum_half  (w_x0),
    .o_diff_half (w_x3)
  );

  idct_half_butterfly #(.LANE_W(LANE_W)) u_bfly_12 (
    .i_a         (r_in[L1*LANE_W +: LANE_W]),
    .i_b         (r_in[L2*LANE_W +: LANE_W]),
    .o_sum_half  (w_x1),
    .o_diff_half (w_x2)
  );

  // Operand select for the shared chain subtractor: x[k] = o[k] - x[k+1].
  always_comb begin
    w_minuend    = r_in[L6*LANE_W +: LANE_W];
    w_subtrahend = r_out[L7*LANE_W +: LANE_W];
    case (r_step)
      2'd2: begin
        w_minuend    = r_in[L5*LANE_W +: LANE_W];
        w_subtrahend = r_out[L6*LANE_W +: LANE_W];
      end
      2'd3: begin
        w_minuend    = r_in[L4*LANE_W +: LANE_W];
        w_subtrahend = r_out[L5*LANE_W +: LANE_W];
      end
      default: ;
    endcase
  end

  assign w_diff = w_minuend - w_subtrahend;

  // Control FSM with the step counter, input latch and registered result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_step  <= '0;
      r_in    <= '0;
      r_out   <= '0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_in_xfer) begin
            r_in    <= i_data_in;
            r_step  <= '0;
            r_state <= SOLVE;
          end
        end
        SOLVE: begin
          r_step <= r_step + 2'd1;
          case (r_step)
            2'd0: begin
              r_out[L0*LANE_W +: LANE_W] <= w_x0;
              r_out[L1*LANE_W +: LANE_W] <= w_x1;
              r_out[L2*LANE_W +: LANE_W] <= w_x2;
              r_out[L3*LANE_W +: LANE_W] <= w_x3;
              r_out[L7*LANE_W +: LANE_W] <= r_in[L7*LANE_W +: LANE_W];
            end
            2'd1: r_out[L6*LANE_W +: LANE_W] <= w_diff;
            2'd2: r_out[L5*LANE_W +: LANE_W] <= w_diff;
            default: begin
              r_out[L4*LANE_W +: LANE_W] <= w_diff;
              r_valid <= 1'b1;
              r_state <= DONE;
            end
          endcase
        end
        DONE: begin
          if (w_out_xfer) begin
            r_valid <= 1'b0;
            if (w_in_xfer) begin
              r_in    <= i_data_in;
              r_step  <= '0;
              r_state <= SOLVE;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_idct_8_stage_2_inner.sv
// Self-checking bench for idct_8_stage_2_inner.
module tb_idct_8_stage_2_inner;

  localparam int LW = 64;
  localparam int DW = 512;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] i_data_in;
  logic          i_valid;
  logic          i_ready;
  logic [DW-1:0] o_data_out;
  logic          o_valid;
  logic          o_ready;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  idct_8_stage_2_inner #(.LANE_W(64), .LANES(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_data_in  (i_data_in),
    .i_valid    (i_valid),
    .i_ready    (i_ready),
    .o_data_out (o_data_out),
    .o_valid    (o_valid),
    .o_ready    (o_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] pack8(input longint v0, v1, v2, v3, v4, v5, v6, v7);
    logic [DW-1:0] w;
    w = {v7, v6, v5, v4, v3, v2, v1, v0};
    return w;
  endfunction

  // Forward stage-2 butterfly applied to x, modulo 2^64 per lane.
  function automatic logic [DW-1:0] fwd(input logic [DW-1:0] xw);
    logic [LW-1:0] x [8];
    for (int k = 0; k < 8; k++) x[k] = xw[k*LW +: LW];
    return {x[7], x[7] + x[6], x[6] + x[5], x[5] + x[4],
            x[0] - x[3], x[1] - x[2], x[1] + x[2], x[0] + x[3]};
  endfunction

  // Send one word from IDLE, check latency and result, optionally hold o_ready low.
  task automatic run_word(input string tag, input logic [DW-1:0] ow, input logic [DW-1:0] xw,
                          input int unsigned hold);
    int unsigned cyc;
    o_ready = (hold == 0);
    chk({tag, "_irdy"}, DW'(i_ready), DW'(1));
    i_valid   = 1'b1;
    i_data_in = ow;
    @(negedge clk);
    i_valid   = 1'b0;
    i_data_in = '0;
    cyc = 0;
    while (!o_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_lat"}, DW'(cyc), DW'(4));
    chk({tag, "_data"}, o_data_out, xw);
    for (int unsigned h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, "_hold"}, o_data_out, xw);
    end
    o_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_vdrop"}, DW'(o_valid), DW'(0));
  endtask

  logic [DW-1:0] t1_o, t1_x, t2_o, t2_x, t6_o, t6_x, xr, other;
  logic [LW-1:0] rnd;
  int unsigned   cyc;

  initial begin
    t1_o = pack8(5, 5, -1, -3, 11, 13, 15, 8);
    t1_x = pack8(1, 2, 3, 4, 5, 6, 7, 8);
    t2_o = pack8(-5, -5, 1, 3, -11, -13, -15, -8);
    t2_x = pack8(-1, -2, -3, -4, -5, -6, -7, -8);
    t6_o = pack8(0, 0, 0, 0, 0, 0, 0, 64'sh8000_0000_0000_0000);
    t6_x = pack8(0, 0, 0, 0, 64'sh8000_0000_0000_0000, 64'sh8000_0000_0000_0000,
                 64'sh8000_0000_0000_0000, 64'sh8000_0000_0000_0000);

    rst = 1'b1; i_valid = 1'b0; i_data_in = '0; o_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_irdy", DW'(i_ready), DW'(0));
    chk("rst_oval", DW'(o_valid), DW'(0));
    chk("rst_data", o_data_out, '0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_irdy", DW'(i_ready), DW'(1));

    // T1, T2 basic and negative
    run_word("t1", t1_o, t1_x, 0);
    run_word("t2", t2_o, t2_x, 0);

    // T3 backpressure with an ignored competing input
    o_ready = 1'b0;
    i_valid = 1'b1; i_data_in = t1_o;
    @(negedge clk);
    i_data_in = t2_o;
    cyc = 0;
    while (!o_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("t3_lat", DW'(cyc), DW'(4));
    for (int unsigned h = 0; h < 10; h++) begin
      chk("t3_data", o_data_out, t1_x);
      chk("t3_irdy", DW'(i_ready), DW'(0));
      @(negedge clk);
    end
    chk("t3_oval", DW'(o_valid), DW'(1));
    i_valid = 1'b0; i_data_in = '0;
    o_ready = 1'b1;
    @(negedge clk);
    chk("t3_xfer", DW'(o_valid), DW'(0));
    chk("t3_idle", DW'(i_ready), DW'(1));

    // T4 back-to-back
    o_ready = 1'b1;
    i_valid = 1'b1; i_data_in = t1_o;
    @(negedge clk);
    i_data_in = t2_o;
    cyc = 0;
    while (!o_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("t4_lat1", DW'(cyc), DW'(4));
    chk("t4_data1", o_data_out, t1_x);
    chk("t4_irdy", DW'(i_ready), DW'(1));
    @(negedge clk);
    i_valid = 1'b0; i_data_in = '0;
    chk("t4_vdrop", DW'(o_valid), DW'(0));
    cyc = 1;
    while (!o_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("t4_gap", DW'(cyc), DW'(5));
    chk("t4_data2", o_data_out, t2_x);
    @(negedge clk);
    chk("t4_end", DW'(o_valid), DW'(0));

    // T5 reset during step 2
    i_valid = 1'b1; i_data_in = t2_o;
    @(negedge clk);
    i_valid = 1'b0; i_data_in = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_oval", DW'(o_valid), DW'(0));
    chk("t5_data", o_data_out, '0);
    chk("t5_irdy_rst", DW'(i_ready), DW'(0));
    rst = 1'b0;
    for (int unsigned h = 0; h < 4; h++) begin
      chk("t5_noval", DW'(o_valid), DW'(0));
      @(negedge clk);
    end
    run_word("t5", t1_o, t1_x, 0);

    // T6 chain wraparound
    run_word("t6", t6_o, t6_x, 0);

    // Random words built from x, forward-transformed, expected to round-trip
    for (int n = 0; n < 20; n++) begin
      for (int k = 0; k < 8; k++) begin
        rnd = {$urandom, $urandom};
        if (k < 4) rnd = LW'($signed(rnd) >>> 2);
        xr[k*LW +: LW] = rnd;
      end
      other = fwd(xr);
      run_word("rnd", other, xr, $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
